dram_write_arbiter: RTL and testbench

- Shares the single DRAM write channel among N_PORT write pipelines; each pipeline's collector presents one cache-line write (address, CSIZE data words, byte-lane mask) per transfer.
- Round-robin grant into a one-entry output register that drives the DRAM write interface.
- Sits in the tile accumulation top level, between the per-pipeline collectors and the DRAM write channel.

---
 rtl/dram_write_arbiter_pkg.sv | 15 +
 rtl/dram_write_arbiter_if.sv | 41 ++++
 rtl/dram_write_arbiter_rr_picker.sv | 21 ++
 rtl/dram_write_arbiter.sv | 81 ++++++++
 tb/tb_dram_write_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/dram_write_arbiter_pkg.sv
// dram_write_arbiter_pkg: shared widths and arbiter types for the DRAM write arbiter
package TauCfg;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW = 16;
  localparam int CACHE_SIZE = 4;
endpackage

package dram_write_arbiter_pkg;
  localparam int DRAMW_ARB_PORTS = 2;
  typedef logic [31:0] ArbCnt;
  typedef enum logic {EMPTY, FULL} slot_e;
  function automatic ArbCnt sat_inc(ArbCnt c);
    return &c ? c : c + 1;
  endfunction
endpackage

// File: rtl/dram_write_arbiter_if.sv
// dram_write_arbiter_if: request bus and DRAM write channel; perf counters present under DRAMW_ARB_PERF_EN
interface dram_write_arbiter_if
  import dram_write_arbiter_pkg::*;
#(
  parameter int N_PORT = DRAMW_ARB_PORTS,
  parameter int GBW = TauCfg::GLOBAL_ADDR_BW,
  parameter int DBW = TauCfg::DATA_BW,
  parameter int CSIZE = TauCfg::CACHE_SIZE,
  localparam int IW = $clog2(N_PORT)
);
  logic [N_PORT-1:0] i_req_rdy;
  logic [N_PORT-1:0] o_req_ack;
  logic [N_PORT-1:0][GBW-1:0] i_req_addr;
  logic [N_PORT-1:0][CSIZE-1:0][DBW-1:0] i_req_data;
  logic [N_PORT-1:0][CSIZE-1:0] i_req_mask;
  logic o_dramw_rdy;
  logic i_dramw_ack;
  logic [GBW-1:0] o_dramwa;
  logic [CSIZE-1:0][DBW-1:0] o_dramwd;
  logic [CSIZE-1:0] o_dramw_mask;
  logic [IW-1:0] o_grant_id;
`ifdef DRAMW_ARB_PERF_EN
  ArbCnt [N_PORT-1:0] o_grant_cnt;
  ArbCnt o_stall_cnt;
  ArbCnt o_conflict_cnt;
`endif
  modport slave (
    input i_req_rdy, i_req_addr, i_req_data, i_req_mask, i_dramw_ack,
    output o_req_ack, o_dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask, o_grant_id
`ifdef DRAMW_ARB_PERF_EN
    , output o_grant_cnt, o_stall_cnt, o_conflict_cnt
`endif
  );
  modport master (
    output i_req_rdy, i_req_addr, i_req_data, i_req_mask, i_dramw_ack,
    input o_req_ack, o_dramw_rdy, o_dramwa, o_dramwd, o_dramw_mask, o_grant_id
`ifdef DRAMW_ARB_PERF_EN
    , input o_grant_cnt, o_stall_cnt, o_conflict_cnt
`endif
  );
endinterface

// File: rtl/dram_write_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first request after ptr_i wins
module rr_picker #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  // Scan farthest offset first so the nearest requester after ptr_i overwrites.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N; i >= 1; i--)
      if (req_i[(int'(ptr_i) + i) % N]) begin
        idx_o = W'((int'(ptr_i) + i) % N);
        gnt_o = N'(1) << idx_o;
      end
  end
endmodule

// File: rtl/dram_write_arbiter.sv
// dram_write_arbiter: round-robin arbitration of write lines into a one-entry DRAM output slot
// Optional DRAMW_ARB_PERF_EN adds saturating grant/stall/conflict counters.
module dram_write_arbiter
  import dram_write_arbiter_pkg::*;
#(
  parameter int N_PORT = DRAMW_ARB_PORTS,
  parameter int GBW = TauCfg::GLOBAL_ADDR_BW,
  parameter int DBW = TauCfg::DATA_BW,
  parameter int CSIZE = TauCfg::CACHE_SIZE,
  localparam int IW = $clog2(N_PORT)
) (
  input logic i_clk,
  input logic i_rst_n,
  dram_write_arbiter_if.slave bus
);
  slot_e state_q, state_d;
  logic [IW-1:0] ptr_q, gid_q, idx;
  logic [N_PORT-1:0] gnt;
  logic slot_free;
  logic [GBW-1:0] addr_q;
  logic [CSIZE-1:0][DBW-1:0] data_q;
  logic [CSIZE-1:0] mask_q;

  rr_picker #(.N(N_PORT)) u_pick (.req_i(bus.i_req_rdy), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(idx));

  assign slot_free = (state_q == EMPTY) || bus.i_dramw_ack;
  assign bus.o_req_ack = slot_free ? gnt : '0;

  always_comb begin
    state_d = |bus.o_req_ack ? FULL : bus.i_dramw_ack ? EMPTY : state_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      ptr_q <= IW'(N_PORT - 1);
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      if (|bus.o_req_ack) begin
        ptr_q <= idx;
        gid_q <= idx;
      end
    end
  end

  // Payload is deliberately unreset; it is only meaningful while FULL.
  always_ff @(posedge i_clk) begin
    if (|bus.o_req_ack) begin
      addr_q <= bus.i_req_addr[idx];
      data_q <= bus.i_req_data[idx];
      mask_q <= bus.i_req_mask[idx];
    end
  end

  assign bus.o_dramw_rdy = state_q == FULL;
  assign bus.o_dramwa = addr_q;
  assign bus.o_dramwd = data_q;
  assign bus.o_dramw_mask = mask_q;
  assign bus.o_grant_id = gid_q;

`ifdef DRAMW_ARB_PERF_EN
  ArbCnt [N_PORT-1:0] gcnt_q;
  ArbCnt scnt_q, ccnt_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      gcnt_q <= '0;
      scnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      for (int i = 0; i < N_PORT; i++)
        if (bus.o_req_ack[i]) gcnt_q[i] <= sat_inc(gcnt_q[i]);
      if (bus.o_dramw_rdy && !bus.i_dramw_ack) scnt_q <= sat_inc(scnt_q);
      if (slot_free && $countones(bus.i_req_rdy) > 1) ccnt_q <= sat_inc(ccnt_q);
    end
  end
  assign bus.o_grant_cnt = gcnt_q;
  assign bus.o_stall_cnt = scnt_q;
  assign bus.o_conflict_cnt = ccnt_q;
`endif
endmodule

// File: tb/tb_dram_write_arbiter.sv
// tb_dram_write_arbiter: directed and random checks of dram_write_arbiter against a behavioural model
module tb_dram_write_arbiter;
  localparam int N = 4;
  localparam int GBW = TauCfg::GLOBAL_ADDR_BW;
  localparam int DBW = TauCfg::DATA_BW;
  localparam int CSIZE = TauCfg::CACHE_SIZE;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int checks = 0;
  int fails = 0;

  dram_write_arbiter_if #(.N_PORT(N), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) bus ();
  dram_write_arbiter #(.N_PORT(N), .GBW(GBW), .DBW(DBW), .CSIZE(CSIZE)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  logic [N-1:0] p_v;
  logic [GBW-1:0] p_addr [N];
  logic [CSIZE-1:0][DBW-1:0] p_data [N];
  logic [CSIZE-1:0] p_mask [N];
  logic [N-1:0] persist;
  logic [GBW-1:0] base [N];
  int rmode = 0;
  int dmode = 0;

  bit m_full = 0;
  int m_ptr = N - 1;
  int m_gid = 0;
  logic [GBW-1:0] m_addr;
  logic [CSIZE-1:0][DBW-1:0] m_data;
  logic [CSIZE-1:0] m_mask;
  longint m_gc [N];
  longint m_sc = 0;
  longint m_cc = 0;

  logic [N-1:0] obs_ack;
  int last_gnt;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_line(int k, logic [GBW-1:0] a);
    p_v[k] = 1'b1;
    p_addr[k] = a;
    p_data[k] = {$urandom(), $urandom()};
    p_mask[k] = CSIZE'($urandom());
  endtask

  task automatic cyc();
    int e;
    logic [N-1:0] eack;
    bit dack;
    for (int k = 0; k < N; k++)
      if (!p_v[k]) begin
        if (rmode == 1 && persist[k]) new_line(k, base[k]);
        if (rmode == 2 && $urandom_range(2) != 0) new_line(k, GBW'($urandom()));
      end
    dack = m_full && (dmode == 1 || (dmode == 2 && $urandom_range(1) == 1));
    bus.i_req_rdy = p_v;
    for (int k = 0; k < N; k++) begin
      bus.i_req_addr[k] = p_addr[k];
      bus.i_req_data[k] = p_data[k];
      bus.i_req_mask[k] = p_mask[k];
    end
    bus.i_dramw_ack = dack;
    #1;
    e = -1;
    if (!m_full || dack)
      for (int j = 1; j <= N; j++)
        if (e < 0 && p_v[(m_ptr + j) % N]) e = (m_ptr + j) % N;
    eack = '0;
    if (e >= 0) eack[e] = 1'b1;
    obs_ack = bus.o_req_ack;
    chk("req_ack", bus.o_req_ack, eack);
    chk("dramw_rdy", bus.o_dramw_rdy, m_full);
    if (m_full) begin
      chk("dramwa", bus.o_dramwa, m_addr);
      chk("dramwd", bus.o_dramwd, m_data);
      chk("dramw_mask", bus.o_dramw_mask, m_mask);
      chk("grant_id", bus.o_grant_id, m_gid);
    end
`ifdef DRAMW_ARB_PERF_EN
    for (int k = 0; k < N; k++) chk("grant_cnt", bus.o_grant_cnt[k], m_gc[k]);
    chk("stall_cnt", bus.o_stall_cnt, m_sc);
    chk("conflict_cnt", bus.o_conflict_cnt, m_cc);
`endif
    @(posedge i_clk);
    if (!i_rst_n) begin
      m_full = 0;
      m_ptr = N - 1;
      m_gid = 0;
      m_sc = 0;
      m_cc = 0;
      for (int k = 0; k < N; k++) m_gc[k] = 0;
    end else begin
      if (m_full && !dack) m_sc++;
      if ((!m_full || dack) && $countones(p_v) > 1) m_cc++;
      if (e >= 0) begin
        m_gc[e]++;
        m_full = 1;
        m_ptr = e;
        m_gid = e;
        m_addr = p_addr[e];
        m_data = p_data[e];
        m_mask = p_mask[e];
        p_v[e] = 1'b0;
      end else if (dack) m_full = 0;
    end
    last_gnt = e;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    p_v = '0;
    rmode = 0;
    dmode = 0;
    i_rst_n = 1'b0;
    cyc();
    cyc();
    i_rst_n = 1'b1;
  endtask

  initial begin
    int prev;
    p_v = '0;
    persist = '0;
    for (int k = 0; k < N; k++) begin
      p_addr[k] = '0;
      p_data[k] = '0;
      p_mask[k] = '0;
      m_gc[k] = 0;
    end
    bus.i_req_rdy = '0;
    bus.i_dramw_ack = 1'b0;
    bus.i_req_addr = '0;
    bus.i_req_data = '0;
    bus.i_req_mask = '0;
    @(negedge i_clk);
    do_reset();
    chk("rst_rdy", bus.o_dramw_rdy, 1'b0);
    chk("rst_gid", bus.o_grant_id, 0);
    // Single request from port 0.
    new_line(0, GBW'(32'h100));
    cyc();
    chk("tp1_ack", obs_ack, 4'b0001);
    chk("tp1_rdy", bus.o_dramw_rdy, 1'b1);
    chk("tp1_addr", bus.o_dramwa, 32'h100);
    chk("tp1_gid", bus.o_grant_id, 0);
    // Ports 0 and 1 request continuously with the output always drained.
    base[0] = GBW'(32'h10);
    base[1] = GBW'(32'h20);
    persist = 4'b0011;
    rmode = 1;
    dmode = 1;
    cyc();
    prev = last_gnt;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("alt_gnt", last_gnt, prev == 0 ? 1 : 0);
      chk("alt_rdy", bus.o_dramw_rdy, 1'b1);
      chk("alt_addr", bus.o_dramwa, last_gnt == 0 ? 32'h10 : 32'h20);
      prev = last_gnt;
    end
    // Output stalled: payload frozen and no grants.
    dmode = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_ack", obs_ack, 4'b0000);
    end
    // Four ports, ptr at 3, requests on 1 and 3.
    do_reset();
    base[1] = GBW'(32'h111);
    base[3] = GBW'(32'h333);
    persist = 4'b1010;
    rmode = 1;
    dmode = 1;
    cyc();
    chk("n4_g0", last_gnt, 1);
    cyc();
    chk("n4_g1", last_gnt, 3);
    chk("n4_nobubble", bus.o_dramw_rdy, 1'b1);
    cyc();
    chk("n4_g2", last_gnt, 1);
    // Reset while FULL discards the line; port 0 then wins first.
    chk("pre_rst_full", bus.o_dramw_rdy, 1'b1);
    p_v = '0;
    rmode = 0;
    dmode = 0;
    i_rst_n = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    chk("rst_full_rdy", bus.o_dramw_rdy, 1'b0);
`ifdef DRAMW_ARB_PERF_EN
    chk("rst_stall_cnt", bus.o_stall_cnt, 0);
    chk("rst_conf_cnt", bus.o_conflict_cnt, 0);
    for (int k = 0; k < N; k++) chk("rst_grant_cnt", bus.o_grant_cnt[k], 0);
`endif
    for (int k = 0; k < N; k++) new_line(k, GBW'(32'h200 + k));
    cyc();
    chk("post_rst_ack", obs_ack, 4'b0001);
    // Random traffic with random drain.
    rmode = 2;
    dmode = 2;
    for (int i = 0; i < 400; i++) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
